// File: rtl/xbox_mac_pkg.sv
// Shared constants and helpers for the xbox MAC datapath.
// Width derivations and the accumulator saturation function.
package xbox_mac_pkg;

  localparam int SAT_W = 64;

  function automatic int prod_w(input int w);
    return 2 * w + 2;
  endfunction

  function automatic int tree_w(input int w, input int n);
    return 2 * w + 2 + $clog2(n);
  endfunction

  // v carries an (acc_w+1)-bit sum sign-extended to SAT_W bits
  function automatic logic signed [SAT_W-1:0] sat_acc(
    input logic signed [SAT_W-1:0] v,
    input int unsigned             acc_w
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/mac_dot_accum_tree.sv
// Registered, stallable binary adder tree with valid/last sideband.
// Each level widens by one bit so no sum is ever truncated.
module mac_adder_tree_pipe #(
  parameter int IN_W = 18,
  parameter int N    = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en_i,
  input  logic                           valid_i,
  input  logic                           last_i,
  input  logic [N*IN_W-1:0]              data_i,
  output logic                           valid_o,
  output logic                           last_o,
  output logic [IN_W+$clog2(N)-1:0]      sum_o
);

  localparam int LVL = $clog2(N);

  for (genvar l = 0; l <= LVL; l++) begin : g_lvl
    localparam int W   = IN_W + l;
    localparam int CNT = N >> l;

    logic signed [W-1:0] s [CNT];
    logic                vld;
    logic                lst;

    if (l == 0) begin : g_in
      for (genvar j = 0; j < CNT; j++) begin : g_lane
        assign s[j] = data_i[j*IN_W +: IN_W];
      end
      assign vld = valid_i;
      assign lst = last_i;
    end else begin : g_add
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld <= 1'b0;
          lst <= 1'b0;
          for (int j = 0; j < CNT; j++) begin
            s[j] <= '0;
          end
        end else if (en_i) begin
          vld <= g_lvl[l-1].vld;
          lst <= g_lvl[l-1].lst;
          for (int j = 0; j < CNT; j++) begin
            s[j] <= W'(g_lvl[l-1].s[2*j])
                  + W'(g_lvl[l-1].s[2*j+1]);
          end
        end
      end
    end
  end

  assign valid_o = g_lvl[LVL].vld;
  assign last_o  = g_lvl[LVL].lst;
  assign sum_o   = g_lvl[LVL].s[0];

endmodule

// File: rtl/mac_dot_accum.sv
// N-lane dot-product engine with saturating multi-beat accumulator.
// Single global enable stalls every pipe register under backpressure.
module mac_dot_accum
  import xbox_mac_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 8,
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WIDTH-1:0] vec_a,
  input  logic [N*WIDTH-1:0] vec_b,
  input  logic               signed_mode,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_result,
  output logic               out_sat,
  output logic [CNT_W-1:0]   out_beats
);

  localparam int PW = prod_w(WIDTH);
  localparam int TW = tree_w(WIDTH, N);

  if (ACC_W < TW) begin : g_bad_acc
    $error("mac_dot_accum: ACC_W too narrow for tree sum");
  end
  if (ACC_W > SAT_W - 1) begin : g_wide_acc
    $error("mac_dot_accum: ACC_W exceeds saturation helper width");
  end
  if ((N < 2) || ((N & (N - 1)) != 0)) begin : g_bad_n
    $error("mac_dot_accum: N must be a power of 2 and >= 2");
  end

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  logic [N*PW-1:0]      prod_d;
  logic [N*PW-1:0]      prod_q;
  logic                 m_valid_q;
  logic                 m_last_q;
  logic signed [WIDTH:0] a_x;
  logic signed [WIDTH:0] b_x;
  logic signed [PW-1:0]  a_w;
  logic signed [PW-1:0]  b_w;
  logic signed [PW-1:0]  p;

  always_comb begin
    prod_d = '0;
    a_x    = '0;
    b_x    = '0;
    a_w    = '0;
    b_w    = '0;
    p      = '0;
    for (int i = 0; i < N; i++) begin
      a_x = $signed({signed_mode & vec_a[i*WIDTH+WIDTH-1],
                     vec_a[i*WIDTH +: WIDTH]});
      b_x = $signed({signed_mode & vec_b[i*WIDTH+WIDTH-1],
                     vec_b[i*WIDTH +: WIDTH]});
      a_w = PW'(a_x);
      b_w = PW'(b_x);
      p   = a_w * b_w;
      prod_d[i*PW +: PW] = p;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      prod_q    <= '0;
    end else if (en) begin
      m_valid_q <= in_valid;
      m_last_q  <= in_last;
      prod_q    <= prod_d;
    end
  end

  logic          t_valid;
  logic          t_last;
  logic [TW-1:0] t_sum;

  mac_adder_tree_pipe #(
    .IN_W (PW),
    .N    (N)
  ) u_tree (
    .clk     (clk),
    .rst     (rst),
    .en_i    (en),
    .valid_i (m_valid_q),
    .last_i  (m_last_q),
    .data_i  (prod_q),
    .valid_o (t_valid),
    .last_o  (t_last),
    .sum_o   (t_sum)
  );

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] base;
  logic signed [TW-1:0]    t_sum_s;
  logic signed [ACC_W:0]   sum_w;
  logic signed [SAT_W-1:0] sum64;
  logic signed [SAT_W-1:0] sat64;
  logic                    clamped;
  logic                    first_q;
  logic                    sticky_q;
  logic                    sticky_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_d;
  logic                    out_valid_q;
  logic [ACC_W-1:0]        out_result_q;
  logic                    out_sat_q;
  logic [CNT_W-1:0]        out_beats_q;

  always_comb begin
    base     = first_q ? '0 : acc_q;
    t_sum_s  = $signed(t_sum);
    sum_w    = (ACC_W+1)'(base) + (ACC_W+1)'(t_sum_s);
    sum64    = SAT_W'(sum_w);
    sat64    = sat_acc(sum64, ACC_W);
    clamped  = (sat64 != sum64);
    acc_d    = sat64[ACC_W-1:0];
    sticky_d = sticky_q | clamped;
    cnt_d    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q        <= '0;
      first_q      <= 1'b1;
      sticky_q     <= 1'b0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_sat_q    <= 1'b0;
      out_beats_q  <= '0;
    end else if (en) begin
      // A landing last beat refills the output even as it drains
      out_valid_q <= t_valid && t_last;
      if (t_valid && t_last) begin
        out_result_q <= acc_d;
        out_sat_q    <= sticky_d;
        out_beats_q  <= cnt_d;
        acc_q        <= '0;
        sticky_q     <= 1'b0;
        cnt_q        <= '0;
        first_q      <= 1'b1;
      end else if (t_valid) begin
        acc_q    <= acc_d;
        sticky_q <= sticky_d;
        cnt_q    <= cnt_d;
        first_q  <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_sat    = out_sat_q;
  assign out_beats  = out_beats_q;

endmodule

// File: tb/tb_mac_dot_accum.sv
// Randomized scoreboard bench for mac_dot_accum.
// Drives two instances (ACC_W 32 and 21) from shared stimulus.
module tb_mac_dot_accum;

  localparam int W  = 8;
  localparam int N  = 8;
  localparam int CW = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           signed_mode;
  logic           in_last;
  logic           out_ready;
  logic [N*W-1:0] vec_a;
  logic [N*W-1:0] vec_b;

  logic           in_ready0, out_valid0, out_sat0;
  logic [31:0]    res0;
  logic [CW-1:0]  beats0;
  logic           in_ready1, out_valid1, out_sat1;
  logic [20:0]    res1;
  logic [CW-1:0]  beats1;

  always #5 clk = ~clk;

  mac_dot_accum #(
    .WIDTH(W), .N(N), .ACC_W(32), .CNT_W(CW)
  ) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready0),
    .vec_a(vec_a), .vec_b(vec_b),
    .signed_mode(signed_mode), .in_last(in_last),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_result(res0), .out_sat(out_sat0),
    .out_beats(beats0)
  );

  mac_dot_accum #(
    .WIDTH(W), .N(N), .ACC_W(21), .CNT_W(CW)
  ) u_sat (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready1),
    .vec_a(vec_a), .vec_b(vec_b),
    .signed_mode(signed_mode), .in_last(in_last),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_result(res1), .out_sat(out_sat1),
    .out_beats(beats1)
  );

  typedef struct {
    longint r;
    bit     s;
    int     b;
  } exp_t;

  exp_t   q0[$];
  exp_t   q1[$];
  longint m_acc[2];
  bit     m_sticky[2];
  int     m_cnt[2];
  int     checks = 0;
  int     errors = 0;
  int     out_count = 0;
  bit     last_acc = 0;

  task automatic check(string tag, longint got, longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint dot_now();
    longint s = 0;
    logic [7:0] av, bv;
    longint a, b;
    for (int i = 0; i < N; i++) begin
      av = vec_a[i*W +: W];
      bv = vec_b[i*W +: W];
      if (signed_mode) begin
        a = longint'($signed(av));
        b = longint'($signed(bv));
      end else begin
        a = longint'(av);
        b = longint'(bv);
      end
      s += a * b;
    end
    return s;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_acc[d] = 0;
      m_sticky[d] = 0;
      m_cnt[d] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_beat(int d, int aw, longint dt);
    longint mx, mn, s;
    exp_t e;
    mx = (64'sd1 <<< (aw - 1)) - 1;
    mn = -mx - 1;
    s = m_acc[d] + dt;
    if (s > mx) begin
      s = mx;
      m_sticky[d] = 1;
    end else if (s < mn) begin
      s = mn;
      m_sticky[d] = 1;
    end
    if (m_cnt[d] < 65535) m_cnt[d]++;
    if (in_last) begin
      e.r = s;
      e.s = m_sticky[d];
      e.b = m_cnt[d];
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
      m_acc[d] = 0;
      m_sticky[d] = 0;
      m_cnt[d] = 0;
    end else begin
      m_acc[d] = s;
    end
  endtask

  task automatic tick();
    bit a0, a1;
    exp_t e;
    longint dt;
    @(negedge clk);
    a0 = in_valid && in_ready0;
    a1 = in_valid && in_ready1;
    if (out_valid0 && !out_ready)
      check("bp_in_ready", in_ready0, 0);
    if (out_valid0 && out_ready) begin
      out_count++;
      if (q0.size() == 0) begin
        check("spurious0", 1, 0);
      end else begin
        e = q0.pop_front();
        check("res0", longint'($signed(res0)), e.r);
        check("sat0", out_sat0, e.s);
        check("beats0", beats0, e.b);
      end
    end
    if (out_valid1 && out_ready) begin
      if (q1.size() == 0) begin
        check("spurious1", 1, 0);
      end else begin
        e = q1.pop_front();
        check("res1", longint'($signed(res1)), e.r);
        check("sat1", out_sat1, e.s);
        check("beats1", beats1, e.b);
      end
    end
    dt = dot_now();
    if (a0) model_beat(0, 32, dt);
    if (a1) model_beat(1, 21, dt);
    last_acc = a0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    model_reset();
    check("rst_valid", out_valid0, 0);
    check("rst_result", res0, 0);
    check("rst_sat", out_sat0, 0);
    check("rst_beats", beats0, 0);
    check("rst_valid1", out_valid1, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid0 && n < 30) begin
      tick();
      n++;
    end
    check("wait_out_valid", out_valid0, 1);
  endtask

  task automatic drain();
    int n;
    in_valid = 0;
    out_ready = 1;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    check("drain_q0", q0.size(), 0);
    check("drain_q1", q1.size(), 0);
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic beat(logic [63:0] a, logic [63:0] b,
                      logic sm, logic last);
    in_valid = 1;
    vec_a = a;
    vec_b = b;
    signed_mode = sm;
    in_last = last;
  endtask

  function automatic logic [63:0] rnd_vec();
    logic [63:0] v;
    logic [7:0] lane;
    case ($urandom_range(0, 5))
      0: lane = 8'h80;
      1: lane = 8'hFF;
      2: lane = 8'h7F;
      default: lane = 8'h00;
    endcase
    if ($urandom_range(0, 2) == 0) v = {8{lane}};
    else v = {$urandom(), $urandom()};
    return v;
  endfunction

  initial begin
    int n, base_cnt, sent, t;
    in_valid = 0;
    in_last = 0;
    signed_mode = 0;
    out_ready = 1;
    vec_a = '0;
    vec_b = '0;
    model_reset();
    do_reset();
    check("rst_in_ready", in_ready0, 1);

    // 1: reset mid-product
    for (int i = 0; i < 3; i++) begin
      beat(rnd_vec(), rnd_vec(), 1, 0);
      tick();
    end
    in_valid = 0;
    tick();
    tick();
    do_reset();
    beat({8{8'h02}}, {8{8'h03}}, 1, 1);
    tick();
    in_valid = 0;
    wait_out(n);
    check("t1_res", longint'($signed(res0)), 48);
    check("t1_beats", beats0, 1);
    drain();

    // 2: signed single beat, latency
    beat({8{8'hFD}}, {8{8'h05}}, 1, 1);
    tick();
    in_valid = 0;
    wait_out(n);
    check("t2_latency", n + 1, 5);
    check("t2_res", longint'($signed(res0)), -120);
    check("t2_beats", beats0, 1);
    drain();

    // 3: unsigned 4-beat
    for (int i = 0; i < 4; i++) begin
      beat({8{8'hFF}}, {8{8'hFF}}, 0, i == 3);
      tick();
    end
    in_valid = 0;
    wait_out(n);
    check("t3_res", longint'($signed(res0)), 2080800);
    check("t3_beats", beats0, 4);
    check("t3_sat", out_sat0, 0);
    drain();

    // 4: saturation on the 21-bit instance
    for (int i = 0; i < 8; i++) begin
      beat({8{8'h80}}, {8{8'h80}}, 1, i == 7);
      tick();
    end
    in_valid = 0;
    wait_out(n);
    check("t4_res1", longint'($signed(res1)), 1048575);
    check("t4_sat1", out_sat1, 1);
    check("t4_res0", longint'($signed(res0)), 1048576);
    check("t4_sat0", out_sat0, 0);
    drain();

    // 5: backpressure, 10 single-beat products
    base_cnt = out_count;
    sent = 0;
    t = 0;
    beat(rnd_vec(), rnd_vec(), $urandom_range(0, 1), 1);
    while (sent < 10 && t < 200) begin
      out_ready = !(t >= 4 && t < 10);
      tick();
      t++;
      if (last_acc) begin
        sent++;
        beat(rnd_vec(), rnd_vec(), $urandom_range(0, 1), 1);
      end
    end
    check("t5_sent", sent, 10);
    drain();
    check("t5_delivered", out_count - base_cnt, 10);

    // 6: drain and fill in the same cycle
    base_cnt = out_count;
    out_ready = 1;
    for (int i = 0; i < 12; i++) begin
      beat(rnd_vec(), rnd_vec(), $urandom_range(0, 1), 1);
      tick();
      if (i >= 4) check("t6_valid", out_valid0, 1);
    end
    drain();
    check("t6_delivered", out_count - base_cnt, 12);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_last = ($urandom_range(0, 2) == 0);
      signed_mode = $urandom_range(0, 1);
      vec_a = rnd_vec();
      vec_b = rnd_vec();
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
